// File: rtl/seq_magnitude_comparator_pkg.sv
// cmp_pkg: shared definitions for the sequential magnitude comparator.
//   state_e    - FSM state encoding (2 bits)
//   idx_width  - width of the slice index counter, clog2(n) with a minimum of 1
package cmp_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/seq_magnitude_comparator_chunk.sv
// chunk_comparator: combinational W-bit unsigned magnitude comparator.
//   a, b  - W-bit operands
//   lt    - a < b
//   eq    - a == b
//   gt    - a > b
// Exactly one output is high for any input pair.
module chunk_comparator #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         lt,
  output logic         eq,
  output logic         gt
);

  assign lt = (a < b);
  assign eq = (a == b);
  assign gt = (a > b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator: multi-cycle signed/unsigned magnitude comparator.
// Walks the captured operands one CHUNK-bit slice per cycle, MS slice first.
//   clk, rst_n          - clock (rising edge), asynchronous active-low reset
//   start               - request, sampled only while idle
//   signed_mode         - two's complement compare when 1 (captured with start)
//   a, b                - WIDTH-bit operands (captured with start)
//   busy                - high whenever a compare is in flight (state != IDLE)
//   done                - one-cycle pulse, new result on lt/eq/gt
//   lt, eq, gt          - registered result, held until the next completion
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = idx_width(NCHUNK);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sm_q, sm_d;
  logic [IW-1:0]    idx_q, idx_d;
  // Sticky first-difference record, only ever set when EARLY_EXIT=0.
  logic             diff_q, diff_d;
  logic             dlt_q, dlt_d;
  logic             dgt_q, dgt_d;
  logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;

  // Slice mux. Flipping the sign bit maps two's complement order onto
  // unsigned order; it only lands in slice 0 since that holds bit WIDTH-1.
  logic [WIDTH-1:0] msb_mask, a_eff, b_eff;
  logic [CHUNK-1:0] a_sl, b_sl;
  logic             c_lt, c_eq, c_gt;
  logic             last;

  always_comb begin
    msb_mask          = '0;
    msb_mask[WIDTH-1] = sm_q;
    a_eff             = a_q ^ msb_mask;
    b_eff             = b_q ^ msb_mask;
    a_sl = CHUNK'(a_eff >> ((NCHUNK - 1 - int'(idx_q)) * CHUNK));
    b_sl = CHUNK'(b_eff >> ((NCHUNK - 1 - int'(idx_q)) * CHUNK));
  end

  chunk_comparator #(.W(CHUNK)) u_chunk (
    .a  (a_sl),
    .b  (b_sl),
    .lt (c_lt),
    .eq (c_eq),
    .gt (c_gt)
  );

  assign last = (idx_q == IW'(NCHUNK - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sm_d    = sm_q;
    idx_d   = idx_q;
    diff_d  = diff_q;
    dlt_d   = dlt_q;
    dgt_d   = dgt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sm_d    = signed_mode;
          idx_d   = '0;
          diff_d  = 1'b0;
          dlt_d   = 1'b0;
          dgt_d   = 1'b0;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        if (((EARLY_EXIT != 0) && !c_eq) || last) begin
          // An earlier recorded difference always wins over this slice.
          lt_d    = diff_q ? dlt_q : c_lt;
          gt_d    = diff_q ? dgt_q : c_gt;
          eq_d    = !diff_q && c_eq;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
          if (!diff_q && !c_eq) begin
            diff_d = 1'b1;
            dlt_d  = c_lt;
            dgt_d  = c_gt;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sm_q    <= 1'b0;
      idx_q   <= '0;
      diff_q  <= 1'b0;
      dlt_q   <= 1'b0;
      dgt_q   <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sm_q    <= sm_d;
      idx_q   <= idx_d;
      diff_q  <= diff_d;
      dlt_q   <= dlt_d;
      dgt_q   <= dgt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign lt   = lt_q;
  assign eq   = eq_q;
  assign gt   = gt_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Scoreboard bench: two DUTs (EARLY_EXIT=1 and EARLY_EXIT=0) share stimulus.
// Expected result and completion cycle are pushed when start is issued;
// per-DUT monitors pop and compare on every done pulse.
module tb_seq_magnitude_comparator;
  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  typedef struct {
    logic [2:0] res;  // {lt, eq, gt}
    int         cyc;  // edge count at which done must be seen
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             signed_mode = 1'b0;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic busy1, done1, lt1, eq1, gt1;
  logic busy0, done0, lt0, eq0, gt0;

  int   cyc = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  exp_t q1[$];
  exp_t q0[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_magnitude_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK), .EARLY_EXIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy1), .done(done1), .lt(lt1), .eq(eq1), .gt(gt1)
  );

  seq_magnitude_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK), .EARLY_EXIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy0), .done(done0), .lt(lt0), .eq(eq0), .gt(gt0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference: ordering by plain arithmetic on the whole operands.
  function automatic logic [2:0] ref_res(input logic [WIDTH-1:0] x, y, input logic sm);
    logic signed [WIDTH-1:0] sx, sy;
    sx = x;
    sy = y;
    if (sm) return {sx < sy, sx == sy, sx > sy};
    return {x < y, x == y, x > y};
  endfunction

  // Index of the first differing CHUNK-bit group counting from the top.
  function automatic int first_diff(input logic [WIDTH-1:0] x, y);
    for (int i = 0; i < NCHUNK; i++)
      if (((x >> ((NCHUNK - 1 - i) * CHUNK)) & ((1 << CHUNK) - 1)) !=
          ((y >> ((NCHUNK - 1 - i) * CHUNK)) & ((1 << CHUNK) - 1)))
        return i;
    return NCHUNK - 1;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done1) begin
      if (q1.size() == 0) chk("dut1 unexpected done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q1.pop_front();
        chk("dut1 result", {29'd0, lt1, eq1, gt1}, {29'd0, e.res});
        chk("dut1 done cycle", cyc, e.cyc);
        chk("dut1 busy at done", {31'd0, busy1}, 32'd1);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done0) begin
      if (q0.size() == 0) chk("dut0 unexpected done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q0.pop_front();
        chk("dut0 result", {29'd0, lt0, eq0, gt0}, {29'd0, e.res});
        chk("dut0 done cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_idle();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!busy1 && !busy0) return;
    end
    chk("idle timeout", 32'd1, 32'd0);
  endtask

  // Called at a negedge with both DUTs idle; start is accepted at the next edge.
  task automatic issue(input logic [WIDTH-1:0] x, y, input logic sm);
    exp_t e;
    wait_idle();
    a = x;
    b = y;
    signed_mode = sm;
    start = 1'b1;
    e.res = ref_res(x, y, sm);
    e.cyc = cyc + first_diff(x, y) + 2;
    q1.push_back(e);
    e.cyc = cyc + NCHUNK + 1;
    q0.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk(nm, {22'd0, busy1, done1, lt1, eq1, gt1, busy0, done0, lt0, eq0, gt0}, 32'd0);
  endtask

  initial begin
    // Asynchronous reset: outputs clear without any clock edge.
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("reset async clear");
    @(negedge clk);
    rst_n = 1'b1;

    issue(32'h12345678, 32'h12345679, 1'b0);
    issue(32'hFF000000, 32'h01000000, 1'b0);
    issue(32'hFF000000, 32'h01000000, 1'b1);
    issue(32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    issue(32'h80000000, 32'h7FFFFFFF, 1'b1);
    issue(32'h80000000, 32'h7FFFFFFF, 1'b0);
    issue(32'h00000000, 32'hFFFFFFFF, 1'b1);

    // Results hold after completion.
    wait_idle();
    repeat (3) @(negedge clk);
    chk("result hold", {29'd0, lt1, eq1, gt1}, 32'b001);

    // Start pulses during CMP/DONE with other operands must be ignored.
    issue(32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    a = 32'h00000001;
    b = 32'hFFFFFFFF;
    start = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;

    // Reset in the middle of a compare discards it.
    issue(32'hCAFEBABE, 32'hCAFEBABE, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    q1.delete();
    q0.delete();
    #1 check_reset_outputs("reset mid-CMP clear");
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'h00000010, 32'h00000001, 1'b0);

    // Randomised operands, biased toward long equal prefixes.
    for (int i = 0; i < 150; i++) begin
      logic [WIDTH-1:0] x, y;
      x = $urandom;
      case ($urandom_range(3))
        0: y = x;
        1: y = x ^ (32'(1) << $urandom_range(WIDTH - 1));
        2: y = $urandom;
        default: y = {x[WIDTH-1:CHUNK], 8'($urandom)};
      endcase
      issue(x, y, 1'($urandom_range(1)));
    end

    wait_idle();
    repeat (2) @(negedge clk);
    chk("scoreboard drained", q1.size() + q0.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
